// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: drives one external 1-bit full adder, LSB first, carry registered.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf_o.
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_init_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             cout_o,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             ovf_o,
`endif
   output logic             fa_s0_o,
   output logic             fa_s1_o,
   output logic             fa_cin_o,
   input  logic             fa_sum_i,
   input  logic             fa_cout_i
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             run;

   assign run = (state_q == StRun);

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_q, ovf_d;
   assign ovf_o = ovf_q;
`endif

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         StIdle: begin
            if (start_i) begin
               a_sh_d  = a_i;
               b_sh_d  = b_i;
               carry_d = cin_init_i;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
            result_d = {fa_sum_i, result_q[WIDTH-1:1]};
            carry_d  = fa_cout_i;
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            cnt_d    = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
               cout_d  = fa_cout_i;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = carry_q ^ fa_cout_i;
`endif
               state_d = StDone;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end
`endif

   assign busy_o   = run;
   assign done_o   = (state_q == StDone);
   assign result_o = result_q;
   assign cout_o   = cout_q;
   assign fa_s0_o  = run & a_sh_q[0];
   assign fa_s1_o  = run & b_sh_q[0];
   assign fa_cin_o = run & carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl with a behavioural full-adder cell and arithmetic model.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W:0]   sum;
   } op_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin_init = 1'b0;
   logic         busy, done, cout;
   logic [W-1:0] result;
   logic         fa_s0, fa_s1, fa_cin, fa_sum, fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   bit hold = 1'b0;
   op_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   assign fa_sum  = fa_s0 ^ fa_s1 ^ fa_cin;
   assign fa_cout = (fa_s0 & fa_s1) | (fa_s0 & fa_cin) | (fa_s1 & fa_cin);

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start),
      .a_i        (a),
      .b_i        (b),
      .cin_init_i (cin_init),
      .busy_o     (busy),
      .done_o     (done),
      .result_o   (result),
      .cout_o     (cout),
`ifdef SERIAL_ADDER_OVF_EN
      .ovf_o      (ovf),
`endif
      .fa_s0_o    (fa_s0),
      .fa_s1_o    (fa_s1),
      .fa_cin_o   (fa_cin),
      .fa_sum_i   (fa_sum),
      .fa_cout_i  (fa_cout)
   );

   function automatic void chk(string name, longint unsigned act, longint unsigned exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endfunction

   // Carry into bit k is bit k of the sum of the operands' low k bits plus cin.
   function automatic logic carry_in_at(op_t o, int k);
      longint unsigned m, s;
      m = (64'd1 << k) - 64'd1;
      s = (longint'(o.a) & m) + (longint'(o.b) & m) + longint'(o.cin);
      return logic'((s >> k) & 64'd1);
   endfunction

   function automatic op_t mk_op(logic [W-1:0] x, logic [W-1:0] y, logic c);
      op_t o;
      o.a = x;
      o.b = y;
      o.cin = c;
      o.sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      return o;
   endfunction

   task automatic set_ops(logic [W-1:0] x, logic [W-1:0] y, logic c);
      a = x;
      b = y;
      cin_init = c;
   endtask

   task automatic scramble_ops();
      set_ops(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4 * W; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            return;
         end
      end
      chk("done_timeout", 0, 1);
   endtask

   task automatic do_op(logic [W-1:0] x, logic [W-1:0] y, logic c);
      bit ok;
      bit idle = 1'b0;
      for (int i = 0; i < 4 * W && !idle; i++) begin
         @(posedge clk);
         #1;
         idle = !busy && !done;
      end
      if (!idle) chk("idle_timeout", 0, 1);
      set_ops(x, y, c);
      start = 1'b1;
      sb.push_back(mk_op(x, y, c));
      @(posedge clk);
      #1;
      start = 1'b0;
      scramble_ops();
      wait_done(ok);
   endtask

   // Monitor: pops an operation when busy rises, checks adder drive per bit and the result at done.
   initial begin
      op_t cur;
      bit active = 1'b0;
      bit prev_done = 1'b0;
      bit have_prev = 1'b0;
      int bit_idx = 0;
      int prev_done_cyc = 0;
      logic [W-1:0] last_res = '0;
      logic last_cout = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_outputs", {busy, done, cout, fa_s0, fa_s1, fa_cin}, 0);
            chk("rst_result", result, 0);
`ifdef SERIAL_ADDER_OVF_EN
            chk("rst_ovf", ovf, 0);
`endif
            active = 1'b0;
            prev_done = 1'b0;
            last_res = '0;
            last_cout = 1'b0;
            continue;
         end
         if (!hold) have_prev = 1'b0;
         if (busy) begin
            if (!active) begin
               chk("sb_has_op", sb.size() > 0, 1);
               if (sb.size() > 0) begin
                  cur = sb.pop_front();
                  active = 1'b1;
                  bit_idx = 0;
               end
            end
            if (active && bit_idx < W) begin
               chk("fa_s0", fa_s0, cur.a[bit_idx]);
               chk("fa_s1", fa_s1, cur.b[bit_idx]);
               chk("fa_cin", fa_cin, carry_in_at(cur, bit_idx));
            end
            bit_idx++;
         end else begin
            chk("fa_idle_zero", {fa_s0, fa_s1, fa_cin}, 0);
         end
         if (done) begin
            chk("done_single", prev_done, 0);
            chk("done_expected", active, 1);
            chk("done_not_busy", busy, 0);
            if (active) begin
               chk("busy_cycles", bit_idx, W);
               chk("result", result, cur.sum[W-1:0]);
               chk("cout", cout, cur.sum[W]);
`ifdef SERIAL_ADDER_OVF_EN
               chk("ovf", ovf, (cur.a[W-1] == cur.b[W-1]) && (cur.sum[W-1] != cur.a[W-1]));
`endif
            end
            if (hold && have_prev) chk("done_period", cyc - prev_done_cyc, W + 2);
            have_prev = hold;
            prev_done_cyc = cyc;
            active = 1'b0;
            last_res = result;
            last_cout = cout;
         end else if (!busy) begin
            chk("hold_result", {last_cout, last_res}, {cout, result});
         end
         prev_done = done;
      end
   end

   initial begin
      bit ok;
      op_t o;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      do_op(8'h01, 8'h02, 1'b0);
      do_op(8'hFF, 8'h01, 1'b0);
      do_op(8'h7F, 8'h01, 1'b0);
      do_op(8'h00, 8'h00, 1'b1);
      do_op(8'hA5, 8'h3C, 1'b1);

      // Start held high with operands changing during RUN: back-to-back ops every W+2 cycles.
      @(posedge clk);
      #1;
      hold = 1'b1;
      set_ops(8'h0F, 8'hF0, 1'b0);
      start = 1'b1;
      sb.push_back(mk_op(8'h0F, 8'hF0, 1'b0));
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         scramble_ops();
         wait_done(ok);
         if (k < 2) begin
            o = mk_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            set_ops(o.a, o.b, o.cin);
            sb.push_back(o);
            @(posedge clk);
         end else begin
            start = 1'b0;
         end
      end
      repeat (3) @(posedge clk);
      hold = 1'b0;

      // Reset in the 4th RUN cycle: outputs clear immediately and no done follows.
      #1;
      set_ops(8'hAA, 8'h55, 1'b0);
      start = 1'b1;
      sb.push_back(mk_op(8'hAA, 8'h55, 1'b0));
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("busy_before_reset", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_outputs", {busy, done, cout, fa_s0, fa_s1, fa_cin}, 0);
      chk("async_rst_result", result, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      do_op(8'hAA, 8'h55, 1'b0);

      for (int i = 0; i < 20; i++) begin
         do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      end

      repeat (5) @(posedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Sequences one shared external full_adder_1bit to add two WIDTH-bit operands bit-serially, LSB first, with a registered carry.
- Sits between a requester (start/busy/done handshake) and the 1-bit adder cell.
- Drives the cell's operand/carry inputs and captures its sum/carry outputs, one bit per clock.
- Trades latency for area: one full adder cell serves any operand width.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
cin_init  input  1  initial carry-in; captured on accepted start
busy  output  1  high while bits are being processed (RUN)
done  output  1  one-cycle pulse; result/cout valid
result  output  WIDTH  sum, registered
cout  output  1  final carry-out, registered
fa_s0  output  1  to adder cell s0 (current A bit)
fa_s1  output  1  to adder cell s1 (current B bit)
fa_cin  output  1  to adder cell cin (registered carry)
fa_sum  input  1  from adder cell sum
fa_cout  input  1  from adder cell cout

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, result=0, cout=0, fa_s0/fa_s1/fa_cin=0.
  - Internal operand shift registers, carry_q and bit counter are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: load a_sh<=a, b_sh<=b, carry_q<=cin_init, cnt<=0, then go to RUN.
  - start=0: remain in IDLE.
- RUN, per cycle:
  - Combinational drive: fa_s0=a_sh[0], fa_s1=b_sh[0], fa_cin=carry_q.
  - At each edge:
    - result<={fa_sum, result[WIDTH-1:1]} (shift right, new bit enters at MSB).
    - carry_q<=fa_cout.
    - a_sh and b_sh shift right by 1.
    - cnt<=cnt+1.
  - When cnt==WIDTH-1 at an edge: cout<=fa_cout, then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- fa_* outputs are 0 in IDLE and DONE.
- Latency: start accepted at edge E → busy high for cycles E+1..E+WIDTH → done high in the cycle after edge E+WIDTH.
  - A new start is accepted earliest at edge E+WIDTH+2.
- result/cout hold their value from DONE until the next accepted start.
  - result is not cleared on start. It shifts during RUN and is not valid while busy=1.
- start while busy=1 or done=1: ignored. No queuing, no change to operands.
- Operand changes after acceptance: a/b/cin_init changing during RUN have no effect.
- Arithmetic: result = (a+b+cin_init) mod 2^WIDTH; cout = bit WIDTH of a+b+cin_init.
- cnt width: $clog2(WIDTH) bits. No wrap-around occurs before the DONE transition.
- Reset mid-RUN: immediate return to IDLE, all outputs at reset values, and no done pulse.
- fa_sum/fa_cout are assumed combinational from fa_* in the same cycle. No registered adder cell is supported.

Optional Feature:
SERIAL_ADDER_OVF_EN:
- Defined:
  - Adds output port ovf (1 bit, reset 0).
  - On the final RUN edge, ovf<=carry_q XOR fa_cout, i.e. signed two's-complement overflow (carry into MSB XOR carry out).
  - ovf holds with result until the next accepted start.
- Undefined: the ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x01, b=0x02, cin_init=0, start 1 cycle → busy high 8 cycles; done pulses once; result=0x03, cout=0.
- a=0xFF, b=0x01, cin_init=0 → result=0x00, cout=1. With SERIAL_ADDER_OVF_EN, ovf=0.
- a=0x7F, b=0x01, cin_init=0 with SERIAL_ADDER_OVF_EN → result=0x80, cout=0, ovf=1. Also a=0x00, b=0x00, cin_init=1 → result=0x01, cout=0.
- a=0x0F, b=0xF0; hold start high continuously and change a/b during RUN → exactly one done per WIDTH+2 cycles; first result=0xFF, cout=0; next operation starts only from IDLE.
- Start a=0xAA, b=0x55; assert rst_n=0 at the 4th RUN cycle → busy/done/result/cout/fa_* all 0 immediately; no done pulse. After release, a=0xAA+0x55 completes with result=0xFF, cout=0.
- Check fa_s0/fa_s1/fa_cin per cycle against the LSB-first bit sequence for a=0xA5, b=0x3C, cin_init=1 → result=0xE2, cout=0.
